// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified memory-port arbiter.
package mem_port_arbiter_pkg;

    localparam int unsigned DEF_ADDR_W = 32;
    localparam int unsigned DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_D = 2'd1,
        GNT_I = 2'd2,
        RESP  = 2'd3
    } state_e;

endpackage

// File: rtl/mem_port_arbiter_starve_counter.sv
// Saturating up-counter with synchronous clear; counts data grants made while a fetch waits.
module mem_port_arbiter_starve_counter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned LIMIT = 4,
    parameter int unsigned W     = $clog2(LIMIT + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    // Clear has priority; increment stops at LIMIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != W'(LIMIT))) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory bus between instruction fetch and load/store.
// One outstanding transaction at a time: IDLE -> GNT_x -> RESP -> IDLE.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W       = DEF_ADDR_W,
    parameter int unsigned DATA_W       = DEF_DATA_W,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ifetch_req,
    input  logic [ADDR_W-1:0] ifetch_addr,
    output logic [DATA_W-1:0] ifetch_rdata,
    output logic              ifetch_valid,
    output logic              stall_if,
    input  logic              dmem_read,
    input  logic              dmem_write,
    input  logic [ADDR_W-1:0] dmem_addr,
    input  logic [DATA_W-1:0] dmem_wdata,
    output logic [DATA_W-1:0] dmem_rdata,
    output logic              dmem_valid,
    output logic              stall_mem,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ready,
    input  logic [DATA_W-1:0] bus_rdata
);

    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    state_e            state;
    logic              dreq;
    logic              starved;
    logic              grant_d;
    logic              grant_i;
    logic              cnt_inc;
    logic              cnt_clr;
    logic [CNT_W-1:0]  starve_cnt;

    // Data normally wins; a waiting fetch wins once it has been passed over STARVE_LIMIT times.
    always_comb begin
        dreq    = dmem_read | dmem_write;
        starved = ifetch_req & (starve_cnt == CNT_W'(STARVE_LIMIT));
        grant_i = (state == IDLE) & ifetch_req & (~dreq | starved);
        grant_d = (state == IDLE) & dreq & ~starved;
        cnt_inc = grant_d & ifetch_req;
        cnt_clr = grant_i | (grant_d & ~ifetch_req);
    end

    mem_port_arbiter_starve_counter #(
        .LIMIT (STARVE_LIMIT),
        .W     (CNT_W)
    ) u_starve_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (cnt_inc),
        .clr   (cnt_clr),
        .count (starve_cnt)
    );

    // Stalls release in the cycle the requester's valid is high.
    always_comb begin
        stall_if  = ifetch_req & ~ifetch_valid;
        stall_mem = dreq & ~dmem_valid;
    end

    // Transaction FSM with registered bus fields and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            bus_req      <= 1'b0;
            bus_we       <= 1'b0;
            bus_addr     <= '0;
            bus_wdata    <= '0;
            ifetch_rdata <= '0;
            dmem_rdata   <= '0;
            ifetch_valid <= 1'b0;
            dmem_valid   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_i) begin
                        state     <= GNT_I;
                        bus_req   <= 1'b1;
                        bus_we    <= 1'b0;
                        bus_addr  <= ifetch_addr;
                        bus_wdata <= '0;
                    end else if (grant_d) begin
                        // read&write together is illegal; it resolves as a write
                        state     <= GNT_D;
                        bus_req   <= 1'b1;
                        bus_we    <= dmem_write;
                        bus_addr  <= dmem_addr;
                        bus_wdata <= dmem_write ? dmem_wdata : '0;
                    end
                end
                GNT_D: begin
                    if (bus_ready) begin
                        state      <= RESP;
                        bus_req    <= 1'b0;
                        bus_we     <= 1'b0;
                        dmem_valid <= 1'b1;
                        if (!bus_we) begin
                            dmem_rdata <= bus_rdata;
                        end
                    end
                end
                GNT_I: begin
                    if (bus_ready) begin
                        state        <= RESP;
                        bus_req      <= 1'b0;
                        ifetch_valid <= 1'b1;
                        ifetch_rdata <= bus_rdata;
                    end
                end
                RESP: begin
                    state        <= IDLE;
                    ifetch_valid <= 1'b0;
                    dmem_valid   <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        ifetch_req;
    logic [31:0] ifetch_addr;
    logic [31:0] ifetch_rdata;
    logic        ifetch_valid;
    logic        stall_if;
    logic        dmem_read;
    logic        dmem_write;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_valid;
    logic        stall_mem;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ready;
    logic [31:0] bus_rdata;

    int checks   = 0;
    int failures = 0;

    mem_port_arbiter #(
        .ADDR_W       (32),
        .DATA_W       (32),
        .STARVE_LIMIT (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ifetch_req   (ifetch_req),
        .ifetch_addr  (ifetch_addr),
        .ifetch_rdata (ifetch_rdata),
        .ifetch_valid (ifetch_valid),
        .stall_if     (stall_if),
        .dmem_read    (dmem_read),
        .dmem_write   (dmem_write),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_rdata   (dmem_rdata),
        .dmem_valid   (dmem_valid),
        .stall_mem    (stall_mem),
        .bus_req      (bus_req),
        .bus_we       (bus_we),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_ready    (bus_ready),
        .bus_rdata    (bus_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; the illegal read+write combination is
    // screened on the inputs the edge is about to see.
    task automatic tick();
        if (rst_n) begin
            assert (!(dmem_read && dmem_write)) else begin
                failures++;
                $error("FAIL illegal_rw observed=11 expected=not_both");
            end
        end
        @(posedge clk);
        #1;
    endtask

    int dcnt;
    int icnt;
    int dsince;

    initial begin
        rst_n       = 1'b0;
        ifetch_req  = 1'b0;
        ifetch_addr = '0;
        dmem_read   = 1'b0;
        dmem_write  = 1'b0;
        dmem_addr   = '0;
        dmem_wdata  = '0;
        bus_ready   = 1'b0;
        bus_rdata   = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk1("rst_bus_req", bus_req, 1'b0);
        chk1("rst_bus_we", bus_we, 1'b0);
        chk32("rst_bus_addr", bus_addr, 32'h0);
        chk32("rst_bus_wdata", bus_wdata, 32'h0);
        chk32("rst_if_rdata", ifetch_rdata, 32'h0);
        chk32("rst_dm_rdata", dmem_rdata, 32'h0);
        chk1("rst_if_valid", ifetch_valid, 1'b0);
        chk1("rst_dm_valid", dmem_valid, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();

        // Reset during GNT_D with bus_ready held low
        dmem_write = 1'b1;
        dmem_addr  = 32'h300;
        dmem_wdata = 32'h12345678;
        @(negedge clk);
        chk1("t1_stall_mem_c0", stall_mem, 1'b1);
        tick();
        @(negedge clk);
        chk1("t1_bus_req_c1", bus_req, 1'b1);
        chk1("t1_bus_we_c1", bus_we, 1'b1);
        chk32("t1_bus_addr_c1", bus_addr, 32'h300);
        #2 rst_n = 1'b0;
        #1;
        chk1("t1_bus_req_rst", bus_req, 1'b0);
        chk1("t1_bus_we_rst", bus_we, 1'b0);
        chk32("t1_state_rst", 32'(dut.state), 32'd0);
        tick();
        rst_n      = 1'b1;
        dmem_write = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk1("t1_no_dm_valid", dmem_valid, 1'b0);
            chk1("t1_no_bus_req", bus_req, 1'b0);
            tick();
        end

        // Lone fetch
        ifetch_req  = 1'b1;
        ifetch_addr = 32'h100;
        @(negedge clk);
        chk1("t2_stall_if_c0", stall_if, 1'b1);
        chk1("t2_bus_req_c0", bus_req, 1'b0);
        tick();
        bus_ready = 1'b1;
        bus_rdata = 32'h00500093;
        @(negedge clk);
        chk1("t2_bus_req_c1", bus_req, 1'b1);
        chk32("t2_bus_addr_c1", bus_addr, 32'h100);
        chk1("t2_bus_we_c1", bus_we, 1'b0);
        chk1("t2_stall_if_c1", stall_if, 1'b1);
        tick();
        bus_ready = 1'b0;
        @(negedge clk);
        chk1("t2_if_valid_c2", ifetch_valid, 1'b1);
        chk32("t2_if_rdata_c2", ifetch_rdata, 32'h00500093);
        chk1("t2_stall_if_c2", stall_if, 1'b0);
        chk1("t2_dm_valid_c2", dmem_valid, 1'b0);
        tick();
        ifetch_req = 1'b0;
        @(negedge clk);
        chk1("t2_if_valid_c3", ifetch_valid, 1'b0);
        tick();

        // Simultaneous load and fetch: data first, fetch in the following IDLE
        dmem_read   = 1'b1;
        dmem_addr   = 32'h200;
        ifetch_req  = 1'b1;
        ifetch_addr = 32'h104;
        bus_ready   = 1'b1;
        bus_rdata   = 32'hAAAA0001;
        @(negedge clk);
        chk1("t3_stall_mem_c0", stall_mem, 1'b1);
        chk1("t3_stall_if_c0", stall_if, 1'b1);
        tick();
        @(negedge clk);
        chk1("t3_bus_req_c1", bus_req, 1'b1);
        chk32("t3_bus_addr_c1", bus_addr, 32'h200);
        chk1("t3_bus_we_c1", bus_we, 1'b0);
        tick();
        @(negedge clk);
        chk1("t3_dm_valid_c2", dmem_valid, 1'b1);
        chk32("t3_dm_rdata_c2", dmem_rdata, 32'hAAAA0001);
        chk1("t3_stall_mem_c2", stall_mem, 1'b0);
        chk1("t3_if_valid_c2", ifetch_valid, 1'b0);
        chk1("t3_bus_req_c2", bus_req, 1'b0);
        tick();
        dmem_read = 1'b0;
        bus_rdata = 32'hBBBB0002;
        @(negedge clk);
        chk1("t3_bus_req_c3", bus_req, 1'b0);
        chk32("t3_state_c3", 32'(dut.state), 32'd0);
        tick();
        @(negedge clk);
        chk1("t3_bus_req_c4", bus_req, 1'b1);
        chk32("t3_bus_addr_c4", bus_addr, 32'h104);
        tick();
        @(negedge clk);
        chk1("t3_if_valid_c5", ifetch_valid, 1'b1);
        chk32("t3_if_rdata_c5", ifetch_rdata, 32'hBBBB0002);
        chk1("t3_dm_valid_c5", dmem_valid, 1'b0);
        tick();
        ifetch_req = 1'b0;
        bus_ready  = 1'b0;
        tick();

        // Store with three wait states; latched fields ignore input changes
        dmem_write = 1'b1;
        dmem_addr  = 32'h300;
        dmem_wdata = 32'hDEADBEEF;
        bus_rdata  = 32'hCCCC0003;
        tick();
        for (int c = 1; c <= 4; c++) begin
            if (c == 2) begin
                dmem_addr  = 32'h999;
                dmem_wdata = 32'h0;
            end
            bus_ready = (c == 4);
            @(negedge clk);
            chk1("t4_bus_req", bus_req, 1'b1);
            chk1("t4_bus_we", bus_we, 1'b1);
            chk32("t4_bus_addr", bus_addr, 32'h300);
            chk32("t4_bus_wdata", bus_wdata, 32'hDEADBEEF);
            chk1("t4_dm_valid_wait", dmem_valid, 1'b0);
            tick();
        end
        bus_ready = 1'b0;
        @(negedge clk);
        chk1("t4_dm_valid", dmem_valid, 1'b1);
        chk32("t4_dm_rdata_kept", dmem_rdata, 32'hAAAA0001);
        chk1("t4_bus_we_after", bus_we, 1'b0);
        tick();
        dmem_write = 1'b0;
        @(negedge clk);
        chk1("t4_dm_valid_once", dmem_valid, 1'b0);
        tick();

        // Starvation: continuous loads with a fetch always waiting
        dmem_read   = 1'b1;
        dmem_addr   = 32'h500;
        ifetch_req  = 1'b1;
        ifetch_addr = 32'h400;
        bus_ready   = 1'b1;
        bus_rdata   = 32'h0;
        dcnt   = 0;
        icnt   = 0;
        dsince = 0;
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            chk1("t5_one_valid", ifetch_valid & dmem_valid, 1'b0);
            if (dmem_valid) begin
                dcnt++;
                dsince++;
            end
            if (ifetch_valid) begin
                icnt++;
                chk32("t5_dgrants_before_fetch", 32'(dsince), 32'd4);
                dsince = 0;
            end
            tick();
        end
        dmem_read  = 1'b0;
        ifetch_req = 1'b0;
        bus_ready  = 1'b0;
        chk32("t5_total_dvalid", 32'(dcnt), 32'd12);
        chk32("t5_total_ivalid", 32'(icnt), 32'd3);
        repeat (3) tick();

        // Held request during RESP is not re-served
        dmem_read = 1'b1;
        dmem_addr = 32'h600;
        bus_ready = 1'b1;
        bus_rdata = 32'h11112222;
        tick();
        @(negedge clk);
        chk1("t6_bus_req_c1", bus_req, 1'b1);
        tick();
        @(negedge clk);
        chk1("t6_dm_valid_c2", dmem_valid, 1'b1);
        chk32("t6_dm_rdata_c2", dmem_rdata, 32'h11112222);
        tick();
        dmem_read = 1'b0;
        for (int c = 3; c <= 6; c++) begin
            @(negedge clk);
            chk1("t6_no_reissue", bus_req, 1'b0);
            chk1("t6_no_dm_valid", dmem_valid, 1'b0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
